// File: rtl/display_7seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
package display_7seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  // Active-low glyphs ordered {a,b,c,d,e,f,g}, indexed by hex nibble.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  // All segments dark, active-low form.
  localparam logic [SEG_W-1:0] GLYPH_OFF = 7'h7F;

  // Converts an active-low glyph to the polarity the board expects.
  function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] glyph_al,
                                                    input logic             active_low);
    return active_low ? glyph_al : ~glyph_al;
  endfunction

endpackage

// File: rtl/decodificador_hex_7seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module decodificador_hex_7seg
  import display_7seg_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_Nibble,
  output logic [SEG_W-1:0]    o_Glifo_c
);

  // Table lookup; the table covers every nibble value.
  assign o_Glifo_c = GLYPH_TABLE[i_Nibble];

endmodule

// File: rtl/display_7seg_multiplexado.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered data,
// guard time between digits and optional leading-zero blanking.
module display_7seg_multiplexado
  import display_7seg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned GUARD          = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned BLANK_LEADING  = 1
) (
  input  logic                         i_Clk,
  input  logic                         i_Reset_n,
  input  logic [NIBBLE_W*N_DIGITS-1:0] i_Dato,
  input  logic [N_DIGITS-1:0]          i_Puntos,
  input  logic                         i_Carga,
  input  logic                         i_Habilita,
  output logic [SEG_W-1:0]             o_Segmentos,
  output logic                         o_Punto,
  output logic [N_DIGITS-1:0]          o_Anodos,
  output logic                         o_Pendiente,
  output logic                         o_Frame
);

  localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DATO_W = NIBBLE_W * N_DIGITS;

  localparam logic SEG_AL   = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_AL    = (AN_ACTIVE_LOW != 0);
  localparam logic BLANK_EN = (BLANK_LEADING != 0);

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_AL}};
  localparam logic [SEG_W-1:0]    SEG_OFF   = seg_polarity(GLYPH_OFF, SEG_AL);

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick_c;
  logic             swap_c;

  // Double buffer
  logic [DATO_W-1:0]   pend_dato_q, pend_dato_d;
  logic [N_DIGITS-1:0] pend_pts_q, pend_pts_d;
  logic                pend_flag_q, pend_flag_d;
  logic [DATO_W-1:0]   disp_dato_q, disp_dato_d;
  logic [N_DIGITS-1:0] disp_pts_q, disp_pts_d;

  // Output registers
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_q, frame_d;

  // Digit selection helpers
  logic [NIBBLE_W-1:0] nib_sel;
  logic                dp_sel;
  logic                blank_sel;
  logic [N_DIGITS-1:0] onehot;
  logic [N_DIGITS-1:0] blank_mask;
  logic                upper_zero;
  logic [SEG_W-1:0]    glyph_al;
  logic                guard_c;

  // Prescaler and digit index; the wrap tick of the last digit is the frame swap.
  always_comb begin
    tick_c = (cnt_q == CNT_LAST);
    swap_c = tick_c && (idx_q == IDX_LAST);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    if (tick_c) begin
      idx_d = swap_c ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Pending/displayed buffers: swap at frame start, a same-cycle load lands in pending.
  always_comb begin
    pend_dato_d = pend_dato_q;
    pend_pts_d  = pend_pts_q;
    pend_flag_d = pend_flag_q;
    disp_dato_d = disp_dato_q;
    disp_pts_d  = disp_pts_q;
    if (swap_c && pend_flag_q) begin
      disp_dato_d = pend_dato_q;
      disp_pts_d  = pend_pts_q;
    end
    if (swap_c) begin
      pend_flag_d = 1'b0;
    end
    if (i_Carga) begin
      pend_dato_d = i_Dato;
      pend_pts_d  = i_Puntos;
      pend_flag_d = 1'b1;
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above it are zero.
  always_comb begin
    blank_mask = '0;
    upper_zero = BLANK_EN;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (disp_dato_q[i*NIBBLE_W +: NIBBLE_W] == '0);
      blank_mask[i] = upper_zero;
    end
  end

  // Pick nibble, DP and blank flag of the digit currently being scanned.
  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    onehot    = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel   = disp_dato_q[i*NIBBLE_W +: NIBBLE_W];
        dp_sel    = disp_pts_q[i];
        blank_sel = blank_mask[i];
        onehot[i] = 1'b1;
      end
    end
  end

  decodificador_hex_7seg u_decodificador (
    .i_Nibble  (nib_sel),
    .o_Glifo_c (glyph_al)
  );

  // Pin values for the current slot; guard time darkens everything to avoid ghosting.
  always_comb begin
    guard_c = (cnt_q < CNT_GUARD);
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = SEG_AL;
    frame_d = swap_c;
    if (!guard_c) begin
      if (i_Habilita) begin
        an_d = AN_AL ? ~onehot : onehot;
      end
      if (!blank_sel) begin
        seg_d = seg_polarity(glyph_al, SEG_AL);
      end
      dp_d = dp_sel ^ SEG_AL;
    end
  end

  // Scan and buffer state.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_dato_q <= '0;
      pend_pts_q  <= '0;
      pend_flag_q <= 1'b0;
      disp_dato_q <= '0;
      disp_pts_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_dato_q <= pend_dato_d;
      pend_pts_q  <= pend_pts_d;
      pend_flag_q <= pend_flag_d;
      disp_dato_q <= disp_dato_d;
      disp_pts_q  <= disp_pts_d;
    end
  end

  // Registered pins.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      seg_q   <= SEG_OFF;
      dp_q    <= SEG_AL;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign o_Segmentos = seg_q;
  assign o_Punto     = dp_q;
  assign o_Anodos    = an_q;
  assign o_Pendiente = pend_flag_q;
  assign o_Frame     = frame_q;

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
// Bench for display_7seg_multiplexado: N=4, DIV=10, GUARD=2, active-low pins.
module tb_display_7seg_multiplexado;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] dato   = '0;
  logic [3:0]  puntos = '0;
  logic        carga  = 1'b0;
  logic        hab    = 1'b1;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pend;
  logic        frame;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: edges since reset release plus buffer contents.
  int          t = 0;
  logic [15:0] m_pend_val, m_disp_val;
  logic [3:0]  m_pend_dp, m_disp_dp;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame, e_pend;

  logic [6:0] GLY [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  always #5 clk = ~clk;

  display_7seg_multiplexado #(
    .N_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .GUARD(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
  ) dut (
    .i_Clk       (clk),
    .i_Reset_n   (rst_n),
    .i_Dato      (dato),
    .i_Puntos    (puntos),
    .i_Carga     (carga),
    .i_Habilita  (hab),
    .o_Segmentos (seg),
    .o_Punto     (dp),
    .o_Anodos    (an),
    .o_Pendiente (pend),
    .o_Frame     (frame)
  );

  task automatic model_reset();
    t = 0;
    m_pend_val = '0; m_disp_val = '0;
    m_pend_dp  = '0; m_disp_dp  = '0;
    m_pend     = 1'b0;
  endtask

  // Advance one clock; expected pins derive from the cycle number alone.
  task automatic step();
    int cnt, dig;
    bit swap, guard, blank;
    logic [3:0] nib;
    cnt   = t % 10;
    dig   = (t / 10) % 4;
    swap  = (cnt == 9) && (dig == 3);
    guard = (cnt < 2);
    nib   = 4'(m_disp_val >> (4 * dig));
    blank = (dig > 0) && ((m_disp_val >> (4 * dig)) == 16'h0);
    e_an    = (guard || !hab) ? 4'hF : ~(4'b0001 << dig);
    e_seg   = (guard || blank) ? 7'h7F : GLY[nib];
    e_dp    = guard ? 1'b1 : ~m_disp_dp[dig];
    e_frame = swap;
    if (swap && m_pend) begin
      m_disp_val = m_pend_val;
      m_disp_dp  = m_pend_dp;
    end
    if (carga) begin
      m_pend_val = dato; m_pend_dp = puntos; m_pend = 1'b1;
    end else if (swap) begin
      m_pend = 1'b0;
    end
    e_pend = m_pend;
    @(posedge clk); #1;
    t++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; carga = 1'b0; hab = 1'b1; dato = '0; puntos = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (an !== 4'hF) $display("FAIL reset_an got %h want f", an); else pass_cnt++;
    total_cnt++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", seg); else pass_cnt++;
    total_cnt++; if (dp !== 1'b1) $display("FAIL reset_dp got %b want 1", dp); else pass_cnt++;
    total_cnt++; if (frame !== 1'b0) $display("FAIL reset_frame got %b want 0", frame); else pass_cnt++;
    total_cnt++; if (pend !== 1'b0) $display("FAIL reset_pend got %b want 0", pend); else pass_cnt++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_scan();
    int first_frame = -1;
    for (int c = 0; c < 100; c++) begin
      step();
      total_cnt++; if (an !== e_an) $display("FAIL idle_an t=%0d got %h want %h", t, an, e_an); else pass_cnt++;
      total_cnt++; if (seg !== e_seg) $display("FAIL idle_seg t=%0d got %h want %h", t, seg, e_seg); else pass_cnt++;
      total_cnt++; if (dp !== e_dp) $display("FAIL idle_dp t=%0d got %b want %b", t, dp, e_dp); else pass_cnt++;
      total_cnt++; if (frame !== e_frame) $display("FAIL idle_frame t=%0d got %b want %b", t, frame, e_frame); else pass_cnt++;
      total_cnt++; if (pend !== e_pend) $display("FAIL idle_pend t=%0d got %b want %b", t, pend, e_pend); else pass_cnt++;
      if (frame === 1'b1 && first_frame < 0) first_frame = t;
      if (an === 4'b1110) begin
        total_cnt++; if (seg !== 7'h01) $display("FAIL idle_digit0 got %h want 01", seg); else pass_cnt++;
      end else if (an !== 4'hF) begin
        total_cnt++; if (seg !== 7'h7F) $display("FAIL idle_blank an=%h got %h want 7f", an, seg); else pass_cnt++;
      end
    end
    total_cnt++;
    if (first_frame != 40) $display("FAIL first_frame got %0d want 40", first_frame); else pass_cnt++;
  endtask

  // Load one value mid-frame, then check every slot of the following frame.
  task automatic test_load_display(input logic [15:0] val, input logic [3:0] pts,
                                   input logic [6:0] s0, input logic [6:0] s1,
                                   input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp_s [4];
    bit seen = 0;
    exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
    while (t % 40 != 10) step();
    carga = 1'b1; dato = val; puntos = pts;
    step();
    carga = 1'b0;
    total_cnt++; if (pend !== 1'b1) $display("FAIL load_pend_rise got %b want 1", pend); else pass_cnt++;
    for (int c = 0; c < 50 && !seen; c++) begin
      step();
      if (frame === 1'b1) seen = 1;
      else begin
        total_cnt++; if (pend !== 1'b1) $display("FAIL load_pend_hold got %b want 1", pend); else pass_cnt++;
      end
    end
    total_cnt++; if (!seen) $display("FAIL load_swap_timeout got 0 want 1"); else pass_cnt++;
    total_cnt++; if (pend !== 1'b0) $display("FAIL load_pend_clear got %b want 0", pend); else pass_cnt++;
    for (int c = 0; c < 40; c++) begin
      step();
      total_cnt++; if (seg !== e_seg) $display("FAIL load_model_seg t=%0d got %h want %h", t, seg, e_seg); else pass_cnt++;
      for (int d = 0; d < 4; d++) begin
        if (an === ~(4'b0001 << d)) begin
          total_cnt++;
          if (seg !== exp_s[d]) $display("FAIL load_slot%0d_seg got %h want %h", d, seg, exp_s[d]); else pass_cnt++;
          total_cnt++;
          if (dp !== ~pts[d]) $display("FAIL load_slot%0d_dp got %b want %b", d, dp, ~pts[d]); else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen_one = 0, seen_two = 0;
    while (t % 40 != 5) step();
    carga = 1'b1; dato = 16'h1111; puntos = 4'b0000;
    step();
    carga = 1'b0;
    while (t % 40 != 20) step();
    carga = 1'b1; dato = 16'h2222;
    step();
    carga = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      total_cnt++; if (seg !== e_seg) $display("FAIL b2b_seg t=%0d got %h want %h", t, seg, e_seg); else pass_cnt++;
      if (an !== 4'hF && seg === 7'h4F) seen_one = 1;
      if (an !== 4'hF && seg === 7'h12) seen_two = 1;
    end
    total_cnt++; if (seen_one) $display("FAIL b2b_first_shown got 1 want 0"); else pass_cnt++;
    total_cnt++; if (!seen_two) $display("FAIL b2b_second_shown got 0 want 1"); else pass_cnt++;
  endtask

  task automatic test_load_on_swap();
    bit ok_old = 0, ok_new = 0;
    while (t % 40 != 10) step();
    carga = 1'b1; dato = 16'h0003; puntos = 4'b0000;
    step();
    carga = 1'b0;
    while (t % 40 != 39) step();
    carga = 1'b1; dato = 16'h0009;
    step();
    carga = 1'b0;
    total_cnt++; if (frame !== 1'b1) $display("FAIL swapload_frame got %b want 1", frame); else pass_cnt++;
    total_cnt++; if (pend !== 1'b1) $display("FAIL swapload_pend got %b want 1", pend); else pass_cnt++;
    for (int c = 0; c < 40; c++) begin
      step();
      if (an === 4'b1110 && seg === 7'h06) ok_old = 1;
    end
    total_cnt++; if (!ok_old) $display("FAIL swapload_old_value got 0 want 1"); else pass_cnt++;
    total_cnt++; if (pend !== 1'b0) $display("FAIL swapload_pend_clear got %b want 0", pend); else pass_cnt++;
    for (int c = 0; c < 40; c++) begin
      step();
      if (an === 4'b1110 && seg === 7'h0C) ok_new = 1;
    end
    total_cnt++; if (!ok_new) $display("FAIL swapload_new_value got 0 want 1"); else pass_cnt++;
  endtask

  task automatic test_habilita();
    int frames = 0;
    hab = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      total_cnt++; if (an !== 4'hF) $display("FAIL hab_an t=%0d got %h want f", t, an); else pass_cnt++;
      total_cnt++; if (frame !== e_frame) $display("FAIL hab_frame t=%0d got %b want %b", t, frame, e_frame); else pass_cnt++;
      if (frame === 1'b1) frames++;
    end
    total_cnt++; if (frames != 1) $display("FAIL hab_frame_count got %0d want 1", frames); else pass_cnt++;
    hab = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      carga  = ($urandom_range(0, 7) == 0);
      dato   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      puntos = 4'($urandom);
      hab    = ($urandom_range(0, 5) != 0);
      step();
      total_cnt++; if (an !== e_an) $display("FAIL rnd_an t=%0d got %h want %h", t, an, e_an); else pass_cnt++;
      total_cnt++; if (seg !== e_seg) $display("FAIL rnd_seg t=%0d got %h want %h", t, seg, e_seg); else pass_cnt++;
      total_cnt++; if (dp !== e_dp) $display("FAIL rnd_dp t=%0d got %b want %b", t, dp, e_dp); else pass_cnt++;
      total_cnt++; if (frame !== e_frame) $display("FAIL rnd_frame t=%0d got %b want %b", t, frame, e_frame); else pass_cnt++;
      total_cnt++; if (pend !== e_pend) $display("FAIL rnd_pend t=%0d got %b want %b", t, pend, e_pend); else pass_cnt++;
    end
    carga = 1'b0;
    hab   = 1'b1;
  endtask

  task automatic test_reset_mid();
    while (t % 40 != 24) step();
    carga = 1'b1; dato = 16'h8888; puntos = 4'b1111;
    step();
    carga = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (an !== 4'hF) $display("FAIL rstmid_an got %h want f", an); else pass_cnt++;
    total_cnt++; if (seg !== 7'h7F) $display("FAIL rstmid_seg got %h want 7f", seg); else pass_cnt++;
    total_cnt++; if (dp !== 1'b1) $display("FAIL rstmid_dp got %b want 1", dp); else pass_cnt++;
    total_cnt++; if (pend !== 1'b0) $display("FAIL rstmid_pend got %b want 0", pend); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 90; c++) begin
      step();
      total_cnt++; if (an !== e_an) $display("FAIL post_rst_an t=%0d got %h want %h", t, an, e_an); else pass_cnt++;
      total_cnt++; if (seg !== e_seg) $display("FAIL post_rst_seg t=%0d got %h want %h", t, seg, e_seg); else pass_cnt++;
      total_cnt++; if (dp !== e_dp) $display("FAIL post_rst_dp t=%0d got %b want %b", t, dp, e_dp); else pass_cnt++;
      total_cnt++; if (frame !== e_frame) $display("FAIL post_rst_frame t=%0d got %b want %b", t, frame, e_frame); else pass_cnt++;
      total_cnt++; if (pend !== e_pend) $display("FAIL post_rst_pend t=%0d got %b want %b", t, pend, e_pend); else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_load_display(16'h12AF, 4'b0010, 7'h38, 7'h08, 7'h12, 7'h4F);
    test_load_display(16'h0050, 4'b0000, 7'h01, 7'h24, 7'h7F, 7'h7F);
    test_back_to_back();
    test_load_on_swap();
    test_habilita();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
